// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
// State enum, opcodes, datapath mux selects and ALU operation codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FN  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  function automatic logic [1:0] imm_src(input logic [6:0] op);
    logic [1:0] r;
    r = IMM_I;
    case (op)
      OP_SW:   r = IMM_S;
      OP_B:    r = IMM_B;
      OP_JAL:  r = IMM_J;
      default: r = IMM_I;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ALUOp/funct decode for the shared ALU.
// The 3-bit operation code is zero-extended to ALU_CTRL_W.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  logic [1:0]            alu_op_i,
  input  logic [2:0]            funct3_i,
  input  logic                  op5_i,
  input  logic                  funct7_5_i,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_o
);

  logic [2:0] code;

  always_comb begin
    code = ALU_ADD;
    case (alu_op_i)
      ALUOP_SUB: code = ALU_SUB;
      ALUOP_FN: begin
        case (funct3_i)
          3'b000:  code = (op5_i && funct7_5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  code = ALU_SLT;
          3'b110:  code = ALU_OR;
          3'b111:  code = ALU_AND;
          default: code = ALU_ADD;
        endcase
      end
      default: code = ALU_ADD;
    endcase
  end

  assign alu_ctrl_o = ALU_CTRL_W'(code);

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing RV32I instructions on the multi-cycle datapath.
// Outputs decode combinationally from state; strobes gated by mem_ready/Zero.
module multicycle_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 3,
  parameter bit EN_BNE     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            Op,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  Zero,
  input  logic                  mem_ready,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ImmSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  illegal_instr,
  output logic                  instr_done
);

  state_e     state_q, state_d;
  logic [1:0] alu_op;
  logic       br_taken;
  logic       unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  assign br_taken = (funct3 == 3'b000 && Zero) ||
                    (EN_BNE && funct3 == 3'b001 && !Zero);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    PCWrite       = 1'b0;
    AdrSrc        = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    ResultSrc     = RES_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RS2;
    alu_op        = ALUOP_ADD;
    illegal_instr = 1'b0;
    instr_done    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_B:         state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d       = S_FETCH;
            illegal_instr = 1'b1;
            instr_done    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        alu_op  = ALUOP_FN;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FN;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        PCWrite    = br_taken;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
    // abort: nothing may be written while reset is held
    if (rst) begin
      PCWrite       = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      RegWrite      = 1'b0;
      illegal_instr = 1'b0;
      instr_done    = 1'b0;
    end
  end

  assign ImmSrc = imm_src(Op);

  mc_alu_decoder #(
    .ALU_CTRL_W(ALU_CTRL_W)
  ) u_alu_dec (
    .alu_op_i  (alu_op),
    .funct3_i  (funct3),
    .op5_i     (Op[5]),
    .funct7_5_i(funct7[5]),
    .alu_ctrl_o(ALUControl)
  );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit against a phase-sequence model.
// Two instances share stimulus: one with bne enabled, one without.
module tb_multicycle_control_unit;

  typedef enum {P_F, P_D, P_MA, P_MR, P_MWB, P_MW,
                P_XR, P_XI, P_WB, P_BR, P_J} phase_e;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, Zero, mem_ready;
  logic [6:0] Op, funct7;
  logic [2:0] funct3;

  logic       pcw_a, adr_a, mw_a, irw_a, rw_a, ill_a, dn_a;
  logic [1:0] rs_a, sa_a, sb_a, imm_a;
  logic [2:0] alu_a;
  logic       pcw_b, adr_b, mw_b, irw_b, rw_b, ill_b, dn_b;
  logic [1:0] rs_b, sa_b, sb_b, imm_b;
  logic [2:0] alu_b;

  multicycle_control_unit #(.ALU_CTRL_W(3), .EN_BNE(1'b1)) dut (
    .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(pcw_a), .AdrSrc(adr_a), .MemWrite(mw_a), .IRWrite(irw_a),
    .RegWrite(rw_a), .ResultSrc(rs_a), .ALUSrcA(sa_a), .ALUSrcB(sb_a),
    .ImmSrc(imm_a), .ALUControl(alu_a), .illegal_instr(ill_a),
    .instr_done(dn_a)
  );

  multicycle_control_unit #(.ALU_CTRL_W(3), .EN_BNE(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(pcw_b), .AdrSrc(adr_b), .MemWrite(mw_b), .IRWrite(irw_b),
    .RegWrite(rw_b), .ResultSrc(rs_b), .ALUSrcA(sa_b), .ALUSrcB(sb_b),
    .ImmSrc(imm_b), .ALUControl(alu_b), .illegal_instr(ill_b),
    .instr_done(dn_b)
  );

  int     n_chk = 0;
  int     n_err = 0;
  phase_e seq[$];
  int     idx;
  bit     last_done;
  int     memw_cnt;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] op);
    return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
           op == 7'b0010011 || op == 7'b1100011 || op == 7'b1101111;
  endfunction

  // Expected output vector for one cycle spent in phase ph.
  function automatic logic [17:0] model(
    input phase_e ph, input logic [6:0] op, input logic [2:0] f3,
    input logic [6:0] f7, input logic mr, input logic z, input logic r,
    input bit en_bne);
    logic       pcw, adr, mw, irw, rw, ill, dn;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alu;
    {pcw, adr, mw, irw, rw, ill, dn} = '0;
    rs = 2'd0; sa = 2'd0; sb = 2'd0; alu = 3'd0;
    if (op == 7'b0100011)      imm = 2'd1;
    else if (op == 7'b1100011) imm = 2'd2;
    else if (op == 7'b1101111) imm = 2'd3;
    else                       imm = 2'd0;
    case (ph)
      P_F:   begin sb = 2; rs = 2; irw = mr; pcw = mr; end
      P_D:   begin sa = 1; sb = 1; ill = !is_legal(op); dn = ill; end
      P_MA:  begin sa = 2; sb = 1; end
      P_MR:  adr = 1;
      P_MWB: begin rs = 1; rw = 1; dn = 1; end
      P_MW:  begin adr = 1; mw = 1; dn = mr; end
      P_XR, P_XI: begin
        sa = 2;
        sb = (ph == P_XI) ? 2'd1 : 2'd0;
        if (f3 == 0)      alu = (op[5] && f7[5]) ? 3'd1 : 3'd0;
        else if (f3 == 2) alu = 5;
        else if (f3 == 6) alu = 3;
        else if (f3 == 7) alu = 2;
      end
      P_WB:  begin rw = 1; dn = 1; end
      P_BR:  begin
        sa = 2; alu = 1; dn = 1;
        pcw = (f3 == 0 && z) || (en_bne && f3 == 1 && !z);
      end
      P_J:   begin sa = 1; sb = 2; pcw = 1; end
      default: ;
    endcase
    if (r) {pcw, mw, irw, rw, ill, dn} = '0;
    return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ill, dn};
  endfunction

  task automatic build_seq();
    seq.delete();
    seq.push_back(P_F);
    seq.push_back(P_D);
    case (Op)
      7'b0000011: begin seq.push_back(P_MA); seq.push_back(P_MR);
                        seq.push_back(P_MWB); end
      7'b0100011: begin seq.push_back(P_MA); seq.push_back(P_MW); end
      7'b0110011: begin seq.push_back(P_XR); seq.push_back(P_WB); end
      7'b0010011: begin seq.push_back(P_XI); seq.push_back(P_WB); end
      7'b1100011: seq.push_back(P_BR);
      7'b1101111: begin seq.push_back(P_J); seq.push_back(P_WB); end
      default: ;
    endcase
    idx = 0;
  endtask

  task automatic step(input logic mr, input logic z, input logic r);
    phase_e      ph;
    logic [17:0] e1, e0, a1, a0;
    mem_ready = mr; Zero = z; rst = r;
    @(negedge clk);
    ph = seq[idx];
    e1 = model(ph, Op, funct3, funct7, mr, z, r, 1'b1);
    e0 = model(ph, Op, funct3, funct7, mr, z, r, 1'b0);
    a1 = {pcw_a, adr_a, mw_a, irw_a, rw_a, rs_a, sa_a, sb_a, imm_a,
          alu_a, ill_a, dn_a};
    a0 = {pcw_b, adr_b, mw_b, irw_b, rw_b, rs_b, sa_b, sb_b, imm_b,
          alu_b, ill_b, dn_b};
    chk($sformatf("%s/bne_on op=%b f3=%0d", ph.name(), Op, funct3),
        32'(a1), 32'(e1));
    chk($sformatf("%s/bne_off op=%b f3=%0d", ph.name(), Op, funct3),
        32'(a0), 32'(e0));
    last_done = dn_a;
    if (mw_a) memw_cnt++;
    if (r) begin
      seq.delete(); seq.push_back(P_F); idx = 0;
    end else if (!((ph == P_F || ph == P_MR || ph == P_MW) && !mr)) begin
      idx++;
    end
    @(posedge clk);
    #1;
  endtask

  // mode 0: random mem_ready, 1: always ready, 2: 3 waits in MEMWRITE.
  // zsel 0/1 fixes Zero, 2 randomizes it.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input int mode,
                           input int zsel);
    int     cyc, waits, done_at, ndone, mwlow;
    phase_e ph;
    logic   mr, z;
    Op = op; funct3 = f3; funct7 = f7;
    build_seq();
    cyc = 0; waits = 0; done_at = -1; ndone = 0; mwlow = 0;
    while (idx < seq.size() && cyc < 40) begin
      ph = seq[idx];
      if (mode == 0)      mr = ($urandom_range(0, 3) != 0);
      else if (mode == 1) mr = 1'b1;
      else                mr = !(ph == P_MW && mwlow < 3);
      if (ph == P_MW && !mr) mwlow++;
      if ((ph == P_F || ph == P_MR || ph == P_MW) && !mr) waits++;
      z = (zsel > 1) ? 1'($urandom_range(0, 1)) : (zsel == 1);
      step(mr, z, 1'b0);
      cyc++;
      if (last_done) begin ndone++; done_at = cyc; end
    end
    chk($sformatf("latency op=%b", op), done_at, seq.size() + waits);
    chk($sformatf("done_count op=%b", op), ndone, 1);
  endtask

  initial begin
    logic [6:0] rop, rf7;
    logic [2:0] rf3;
    int         k;
    rst = 1'b1; mem_ready = 1'b1; Zero = 1'b0;
    Op = 7'b0000011; funct3 = 3'd0; funct7 = 7'd0;
    seq.delete(); seq.push_back(P_F); idx = 0;
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);

    run_instr(7'b0000011, 3'd2, 7'd0, 1, 2);
    memw_cnt = 0;
    run_instr(7'b0100011, 3'd2, 7'd0, 2, 2);
    chk("sw_memwrite_cycles", memw_cnt, 4);
    run_instr(7'b0110011, 3'd0, 7'b0100000, 1, 2);
    run_instr(7'b0010011, 3'd0, 7'b0100000, 1, 2);
    run_instr(7'b1100011, 3'd0, 7'd0, 1, 1);
    run_instr(7'b1100011, 3'd0, 7'd0, 1, 0);
    run_instr(7'b1100011, 3'd1, 7'd0, 1, 0);
    run_instr(7'b1100011, 3'd1, 7'd0, 1, 1);
    run_instr(7'b1100011, 3'd4, 7'd0, 1, 0);
    run_instr(7'b1101111, 3'd0, 7'd0, 1, 2);
    run_instr(7'b1110011, 3'd0, 7'd0, 1, 2);

    Op = 7'b0100011; funct3 = 3'd2; funct7 = 7'd0;
    build_seq();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("reset_abort_no_done", last_done, 0);
    run_instr(7'b0000011, 3'd2, 7'd0, 1, 2);

    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 6);
      case (k)
        0: rop = 7'b0000011;
        1: rop = 7'b0100011;
        2: rop = 7'b0110011;
        3: rop = 7'b0010011;
        4: rop = 7'b1100011;
        5: rop = 7'b1101111;
        default: begin
          rop = 7'($urandom);
          while (is_legal(rop)) rop = 7'($urandom);
        end
      endcase
      case ($urandom_range(0, 4))
        0: rf3 = 3'd0;
        1: rf3 = 3'd1;
        2: rf3 = 3'd2;
        3: rf3 = 3'd6;
        default: rf3 = 3'($urandom);
      endcase
      case ($urandom_range(0, 2))
        0: rf7 = 7'd0;
        1: rf7 = 7'b0100000;
        default: rf7 = 7'($urandom);
      endcase
      run_instr(rop, rf3, rf7, 0, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
